// File: rtl/stripe_pkg.sv
// Shared types and constants for the 1:2 byte striping controller.
package stripe_pkg;

  // Striping sequence: lane 0, lane 1, and the optional pad slot on lane 1.
  typedef enum logic [1:0] {
    S_L0  = 2'd0,
    S_L1  = 2'd1,
    S_PAD = 2'd2
  } state_e;

  // Filler byte written to lane 1 to close an odd-length packet.
  localparam logic [7:0] PAD_BYTE_DEFAULT = 8'hF7;

  // Lane indices into the per-lane signal arrays.
  localparam int LANE0 = 0;
  localparam int LANE1 = 1;

endpackage

// File: rtl/lane_hold_reg.sv
// One-deep holding register for a single lane: keeps one byte plus its
// valid flag and accepts a new byte in the same cycle the old one drains.
module lane_hold_reg
  import stripe_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              free
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  // Empty, or the held byte leaves this cycle.
  assign free  = ~valid_q | ready;
  assign dout  = data_q;
  assign valid = valid_q;

  // Load wins over drain; a drain alone only drops valid and keeps the byte.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = din;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Holding register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/stripe_ctrl_1x2.sv
// Round-robin 1:2 byte striping controller: lane-select FSM, per-lane
// holding registers and a completed-pair counter.
// Optional build macro STRIPE_PAD_EN: a last byte landing on lane 0 is
// followed by PAD_BYTE on lane 1 so every packet ends lane-aligned.
module stripe_ctrl_1x2
  import stripe_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                CNT_W    = 8,
  parameter logic [DATA_W-1:0] PAD_BYTE = DATA_W'(PAD_BYTE_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0,
  input  logic              in0_valid,
  input  logic              in0_last,
  output logic              in0_ready,
  output logic [DATA_W-1:0] out0,
  output logic              valid_out0,
  input  logic              ready_out0,
  output logic [DATA_W-1:0] out1,
  output logic              valid_out1,
  input  logic              ready_out1,
  output logic [CNT_W-1:0]  pair_cnt
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  pair_cnt_q, pair_cnt_d;

  logic [1:0]        lane_load;
  logic [1:0]        lane_rdy;
  logic [1:0]        lane_vld;
  logic [1:0]        lane_free;
  logic [DATA_W-1:0] lane_din  [2];
  logic [DATA_W-1:0] lane_dout [2];

  logic              ready_raw;
  logic              accept;
  logic              pad_fire;

  assign lane_rdy[LANE0] = ready_out0;
  assign lane_rdy[LANE1] = ready_out1;
  assign out0            = lane_dout[LANE0];
  assign out1            = lane_dout[LANE1];
  assign valid_out0      = lane_vld[LANE0];
  assign valid_out1      = lane_vld[LANE1];
  assign pair_cnt        = pair_cnt_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      lane_hold_reg #(
        .DATA_W (DATA_W)
      ) u_lane (
        .clk   (clk),
        .reset (reset),
        .load  (lane_load[gi]),
        .din   (lane_din[gi]),
        .ready (lane_rdy[gi]),
        .dout  (lane_dout[gi]),
        .valid (lane_vld[gi]),
        .free  (lane_free[gi])
      );
    end
  endgenerate

  // Source handshake: ready only when the lane the FSM points at can take a byte.
  always_comb begin
    ready_raw = 1'b0;
    case (state_q)
      S_L0:    ready_raw = lane_free[LANE0];
      S_L1:    ready_raw = lane_free[LANE1];
      default: ready_raw = 1'b0;
    endcase
  end

  // Never advertise ready while reset is held.
  assign in0_ready = ready_raw & reset;
  assign accept    = in0_valid & in0_ready;

`ifdef STRIPE_PAD_EN
  assign pad_fire = (state_q == S_PAD) & lane_free[LANE1];
`else
  // Without padding the last flag carries no meaning for striping.
  logic unused_in0_last;
  assign unused_in0_last = in0_last;
  assign pad_fire        = 1'b0;
`endif

  // Lane load steering: lane 1 takes either the source byte or the pad byte.
  always_comb begin
    lane_load[LANE0] = accept & (state_q == S_L0);
    lane_load[LANE1] = (accept & (state_q == S_L1)) | pad_fire;
    lane_din[LANE0]  = in0;
    lane_din[LANE1]  = pad_fire ? PAD_BYTE : in0;
  end

  // Next-state and pair counting; a pair completes whenever lane 1 is loaded.
  always_comb begin
    state_d    = state_q;
    pair_cnt_d = pair_cnt_q;
    case (state_q)
      S_L0: begin
        if (accept) begin
`ifdef STRIPE_PAD_EN
          state_d = in0_last ? S_PAD : S_L1;
`else
          state_d = S_L1;
`endif
        end
      end
      S_L1: begin
        if (accept) begin
          state_d    = S_L0;
          pair_cnt_d = pair_cnt_q + CNT_W'(1);
        end
      end
      S_PAD: begin
        if (pad_fire) begin
          state_d    = S_L0;
          pair_cnt_d = pair_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_L0;
    endcase
  end

  // FSM state and pair counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_L0;
      pair_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

endmodule

// File: tb/tb_stripe_ctrl_1x2.sv
// Directed vector bench for stripe_ctrl_1x2. A second instance with a
// 2-bit pair counter runs on the same stimulus to exercise counter wrap.
module tb_stripe_ctrl_1x2;

  typedef struct {
    logic       vld;
    logic [7:0] din;
    logic       last;
    logic       r0;
    logic       r1;
    logic       er;
    logic       ev0;
    logic [7:0] eo0;
    logic       ev1;
    logic [7:0] eo1;
    logic [7:0] ecnt;
  } vec_t;

`ifdef STRIPE_PAD_EN
  localparam logic [7:0] TAIL0 = 8'h22;
  localparam logic [7:0] TAIL1 = 8'h33;
`else
  localparam logic [7:0] TAIL0 = 8'h33;
  localparam logic [7:0] TAIL1 = 8'h44;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] in0;
  logic       in0_valid;
  logic       in0_last;
  logic       ready_out0;
  logic       ready_out1;

  logic       in0_ready,  in0_ready_b;
  logic [7:0] out0,       out0_b;
  logic       valid_out0, valid_out0_b;
  logic [7:0] out1,       out1_b;
  logic       valid_out1, valid_out1_b;
  logic [7:0] pair_cnt;
  logic [1:0] pair_cnt_b;

  int n_vec;
  int n_bad;

  stripe_ctrl_1x2 #(.DATA_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in0        (in0),
    .in0_valid  (in0_valid),
    .in0_last   (in0_last),
    .in0_ready  (in0_ready),
    .out0       (out0),
    .valid_out0 (valid_out0),
    .ready_out0 (ready_out0),
    .out1       (out1),
    .valid_out1 (valid_out1),
    .ready_out1 (ready_out1),
    .pair_cnt   (pair_cnt)
  );

  stripe_ctrl_1x2 #(.DATA_W(8), .CNT_W(2)) dut_w2 (
    .clk        (clk),
    .reset      (reset),
    .in0        (in0),
    .in0_valid  (in0_valid),
    .in0_last   (in0_last),
    .in0_ready  (in0_ready_b),
    .out0       (out0_b),
    .valid_out0 (valid_out0_b),
    .ready_out0 (ready_out0),
    .out1       (out1_b),
    .valid_out1 (valid_out1_b),
    .ready_out1 (ready_out1),
    .pair_cnt   (pair_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic vld, input logic [7:0] din, input logic last,
                              input logic r0, input logic r1, input logic er,
                              input logic ev0, input logic [7:0] eo0,
                              input logic ev1, input logic [7:0] eo1,
                              input logic [7:0] ecnt);
    vec_t v;
    v.vld = vld; v.din = din; v.last = last; v.r0 = r0; v.r1 = r1;
    v.er = er; v.ev0 = ev0; v.eo0 = eo0; v.ev1 = ev1; v.eo1 = eo1; v.ecnt = ecnt;
    return v;
  endfunction

  // Registered outputs of both instances plus the given ready sample.
  function automatic logic [47:0] snap(input logic rdy_a, input logic rdy_b);
    return {rdy_a, valid_out0, out0, valid_out1, out1, pair_cnt,
            rdy_b, valid_out0_b, out0_b, valid_out1_b, out1_b, pair_cnt_b};
  endfunction

  function automatic logic [47:0] expect_of(input vec_t v);
    return {v.er, v.ev0, v.eo0, v.ev1, v.eo1, v.ecnt,
            v.er, v.ev0, v.eo0, v.ev1, v.eo1, v.ecnt[1:0]};
  endfunction

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Called just after a rising edge: drive, sample ready mid-cycle, then
  // sample the registered outputs just after the next edge.
  task automatic apply(input string name, input vec_t v);
    logic ra, rb;
    in0_valid  = v.vld;
    in0        = v.din;
    in0_last   = v.last;
    ready_out0 = v.r0;
    ready_out1 = v.r1;
    #4;
    ra = in0_ready;
    rb = in0_ready_b;
    @(posedge clk);
    #1;
    check(name, snap(ra, rb), expect_of(v));
    $display("%s: in=%h vld=%b rdy=%b out0=%h/%b out1=%h/%b cnt=%0d", name,
             v.din, v.vld, ra, out0, valid_out0, out1, valid_out1, pair_cnt);
  endtask

  vec_t tbl[$];

  initial begin
    logic [7:0] b, l0, l1;
    n_vec = 0;
    n_bad = 0;

    // Streaming, then lane 1 backpressure, then lane 0 stall.
    tbl.push_back(mk(1, 8'h01, 0, 1, 1,  1, 1, 8'h01, 0, 8'h00, 8'd0));
    tbl.push_back(mk(1, 8'h02, 0, 1, 1,  1, 0, 8'h01, 1, 8'h02, 8'd1));
    tbl.push_back(mk(1, 8'h03, 0, 1, 1,  1, 1, 8'h03, 0, 8'h02, 8'd1));
    tbl.push_back(mk(1, 8'h04, 0, 1, 1,  1, 0, 8'h03, 1, 8'h04, 8'd2));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1,  1, 0, 8'h03, 0, 8'h04, 8'd2));
    tbl.push_back(mk(1, 8'h0A, 0, 1, 0,  1, 1, 8'h0A, 0, 8'h04, 8'd2));
    tbl.push_back(mk(1, 8'h0B, 0, 1, 0,  1, 0, 8'h0A, 1, 8'h0B, 8'd3));
    tbl.push_back(mk(1, 8'h0C, 0, 1, 0,  1, 1, 8'h0C, 1, 8'h0B, 8'd3));
    tbl.push_back(mk(1, 8'h0D, 0, 1, 0,  0, 0, 8'h0C, 1, 8'h0B, 8'd3));
    tbl.push_back(mk(1, 8'h0D, 0, 1, 0,  0, 0, 8'h0C, 1, 8'h0B, 8'd3));
    tbl.push_back(mk(1, 8'h0D, 0, 1, 1,  1, 0, 8'h0C, 1, 8'h0D, 8'd4));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1,  1, 0, 8'h0C, 0, 8'h0D, 8'd4));
    tbl.push_back(mk(1, 8'h0E, 0, 0, 1,  1, 1, 8'h0E, 0, 8'h0D, 8'd4));
    tbl.push_back(mk(1, 8'h0F, 0, 0, 1,  1, 1, 8'h0E, 1, 8'h0F, 8'd5));
    tbl.push_back(mk(1, 8'h10, 0, 0, 1,  0, 1, 8'h0E, 0, 8'h0F, 8'd5));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1,  1, 0, 8'h0E, 0, 8'h0F, 8'd5));
    // Odd-length packet: one byte marked last.
    tbl.push_back(mk(1, 8'h11, 1, 1, 1,  1, 1, 8'h11, 0, 8'h0F, 8'd5));
`ifdef STRIPE_PAD_EN
    tbl.push_back(mk(1, 8'h22, 0, 1, 1,  0, 0, 8'h11, 1, 8'hF7, 8'd6));
    tbl.push_back(mk(1, 8'h22, 0, 1, 1,  1, 1, 8'h22, 0, 8'hF7, 8'd6));
    tbl.push_back(mk(1, 8'h33, 0, 1, 1,  1, 0, 8'h22, 1, 8'h33, 8'd7));
`else
    tbl.push_back(mk(1, 8'h22, 0, 1, 1,  1, 0, 8'h11, 1, 8'h22, 8'd6));
    tbl.push_back(mk(1, 8'h33, 0, 1, 1,  1, 1, 8'h33, 0, 8'h22, 8'd6));
    tbl.push_back(mk(1, 8'h44, 0, 1, 1,  1, 0, 8'h33, 1, 8'h44, 8'd7));
`endif
    // Set up S_L1 with lane 1 stuck full, for the mid-operation reset.
    tbl.push_back(mk(0, 8'h00, 0, 1, 1,  1, 0, TAIL0, 0, TAIL1, 8'd7));
    tbl.push_back(mk(1, 8'h55, 0, 1, 0,  1, 1, 8'h55, 0, TAIL1, 8'd7));
    tbl.push_back(mk(1, 8'h66, 0, 1, 0,  1, 0, 8'h55, 1, 8'h66, 8'd8));
    tbl.push_back(mk(1, 8'h77, 0, 1, 0,  1, 1, 8'h77, 1, 8'h66, 8'd8));

    // Reset held with a byte offered: nothing accepted, all outputs clear.
    reset      = 1'b0;
    in0_valid  = 1'b1;
    in0        = 8'hAA;
    in0_last   = 1'b0;
    ready_out0 = 1'b1;
    ready_out1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset_hold%0d", i), snap(in0_ready, in0_ready_b), 48'h0);
      $display("reset_hold%0d: rdy=%b v0=%b v1=%b cnt=%0d", i, in0_ready, valid_out0,
               valid_out1, pair_cnt);
    end
    reset = 1'b1;

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // Asynchronous reset mid-cycle while in S_L1 with lane 1 held.
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", snap(in0_ready, in0_ready_b), 48'h0);
    $display("async_reset: rdy=%b v0=%b v1=%b out1=%h cnt=%0d", in0_ready, valid_out0,
             valid_out1, out1, pair_cnt);
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply("post_reset0", mk(1, 8'h88, 0, 1, 1,  1, 1, 8'h88, 0, 8'h00, 8'd0));
    apply("post_reset1", mk(1, 8'h99, 0, 1, 1,  1, 0, 8'h88, 1, 8'h99, 8'd1));

    // Fresh reset, then ten bytes: the 2-bit counter runs 1,2,3,0,1.
    reset = 1'b0;
    #1;
    check("wrap_reset", snap(in0_ready, in0_ready_b), 48'h0);
    $display("wrap_reset: rdy=%b cnt=%0d", in0_ready, pair_cnt);
    @(posedge clk);
    #1;
    reset = 1'b1;
    l0 = 8'h00;
    l1 = 8'h00;
    for (int i = 0; i < 10; i++) begin
      b = 8'hA0 + 8'(i);
      if (i % 2 == 0) begin
        apply($sformatf("wrap%0d", i), mk(1, b, 0, 1, 1,  1, 1, b, 0, l1, 8'((i + 1) / 2)));
        l0 = b;
      end else begin
        apply($sformatf("wrap%0d", i), mk(1, b, 0, 1, 1,  1, 0, l0, 1, b, 8'((i + 1) / 2)));
        l1 = b;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
